// File: rtl/s_machine_sequencer.sv
// s_machine_sequencer: fetch/issue controller for the S-Machine CPU.
//
// Owns the program counter and fetches 16-bit words from the shared 256x16
// synchronous-read memory. Each non-HALT word is issued to the interpreter
// with a one-cycle start pulse. The sequencer then waits for done and either
// advances the PC or reloads it. The single memory port belongs to the
// interpreter only while an instruction is in WAIT.
//
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   run, halt_req         start from IDLE / stop cleanly at the next boundary
//   mem_*                 shared memory bus (address, rw, write data, read data)
//   interp_inst/start     instruction register and issue pulse to the interpreter
//   interp_done/addr/rw/data_out/pc_load/pc_target
//                         interpreter completion, memory request and PC redirect
//   pc, busy, halted, fault, inst_count
//                         status
module s_machine_sequencer #(
    parameter logic [7:0]  RESET_PC    = 8'h00,
    parameter logic [3:0]  HALT_OPCODE = 4'hF,
    parameter int unsigned TIMEOUT     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        halt_req,
    input  logic [15:0] mem_data_in,
    output logic [7:0]  mem_addr,
    output logic        mem_rw,
    output logic [15:0] mem_data_out,
    output logic [15:0] interp_inst,
    output logic        interp_start,
    input  logic        interp_done,
    input  logic [7:0]  interp_addr,
    input  logic        interp_rw,
    input  logic [15:0] interp_data_out,
    input  logic        interp_pc_load,
    input  logic [7:0]  interp_pc_target,
    output logic [7:0]  pc,
    output logic        busy,
    output logic        halted,
    output logic        fault,
    output logic [15:0] inst_count
);

    localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLatch,
        StIssue,
        StWait,
        StUpdate,
        StHalted,
        StFault
    } state_e;

    state_e      state_q;
    logic [7:0]  pc_q;
    logic [7:0]  seq_addr_q;
    logic [15:0] inst_q;
    logic        start_q;
    logic        busy_q;
    logic        halted_q;
    logic        fault_q;
    logic [15:0] count_q;
    logic [7:0]  tmo_q;
    logic        pc_load_q;
    logic [7:0]  pc_target_q;
    logic [7:0]  pc_next;

    // Redirect values are captured with done in WAIT and consumed in UPDATE.
    assign pc_next = pc_load_q ? pc_target_q : pc_q + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            pc_q        <= RESET_PC;
            seq_addr_q  <= 8'h00;
            inst_q      <= 16'h0000;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
            fault_q     <= 1'b0;
            count_q     <= 16'h0000;
            tmo_q       <= 8'h00;
            pc_load_q   <= 1'b0;
            pc_target_q <= 8'h00;
        end else begin
            start_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (run) begin
                        state_q    <= StFetch;
                        seq_addr_q <= pc_q;
                        busy_q     <= 1'b1;
                    end
                end
                StFetch: begin
                    // Address is already pc; data arrives next cycle.
                    state_q <= StLatch;
                end
                StLatch: begin
                    inst_q <= mem_data_in;
                    if (mem_data_in[15:12] == HALT_OPCODE) begin
                        state_q  <= StHalted;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                    end else begin
                        state_q <= StIssue;
                        start_q <= 1'b1;
                    end
                end
                StIssue: begin
                    tmo_q   <= 8'h00;
                    state_q <= StWait;
                end
                StWait: begin
                    if (interp_done) begin
                        pc_load_q   <= interp_pc_load;
                        pc_target_q <= interp_pc_target;
                        state_q     <= StUpdate;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                        if (tmo_q + 8'd1 == TimeoutLimit) begin
                            state_q <= StFault;
                            busy_q  <= 1'b0;
                            fault_q <= 1'b1;
                        end
                    end
                end
                StUpdate: begin
                    pc_q       <= pc_next;
                    seq_addr_q <= pc_next;
                    if (count_q != 16'hFFFF) begin
                        count_q <= count_q + 16'd1;
                    end
                    if (halt_req) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= StFetch;
                    end
                end
                StHalted, StFault: begin
                    // Sticky until rst.
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Memory port mux: the interpreter owns the bus only while in WAIT.
    always_comb begin
        mem_addr     = seq_addr_q;
        mem_rw       = 1'b0;
        mem_data_out = 16'h0000;
        if (state_q == StWait) begin
            mem_addr     = interp_addr;
            mem_rw       = interp_rw;
            mem_data_out = interp_data_out;
        end
    end

    assign interp_inst  = inst_q;
    assign interp_start = start_q;
    assign pc           = pc_q;
    assign busy         = busy_q;
    assign halted       = halted_q;
    assign fault        = fault_q;
    assign inst_count   = count_q;

endmodule

// File: tb/tb_s_machine_sequencer.sv
// Testbench for s_machine_sequencer: a synchronous-read program memory, a
// scripted interpreter and a per-instruction reference model (pc, count).
module tb_s_machine_sequencer;

    localparam int unsigned TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        halt_req;
    logic [15:0] mem_data_in;
    logic [7:0]  mem_addr;
    logic        mem_rw;
    logic [15:0] mem_data_out;
    logic [15:0] interp_inst;
    logic        interp_start;
    logic        interp_done;
    logic [7:0]  interp_addr;
    logic        interp_rw;
    logic [15:0] interp_data_out;
    logic        interp_pc_load;
    logic [7:0]  interp_pc_target;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;
    logic        fault;
    logic [15:0] inst_count;

    logic [15:0] prog [256];
    logic [7:0]  pc_m;
    logic [15:0] count_m;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          starts = 0;

    s_machine_sequencer #(
        .RESET_PC   (8'h00),
        .HALT_OPCODE(4'hF),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .run             (run),
        .halt_req        (halt_req),
        .mem_data_in     (mem_data_in),
        .mem_addr        (mem_addr),
        .mem_rw          (mem_rw),
        .mem_data_out    (mem_data_out),
        .interp_inst     (interp_inst),
        .interp_start    (interp_start),
        .interp_done     (interp_done),
        .interp_addr     (interp_addr),
        .interp_rw       (interp_rw),
        .interp_data_out (interp_data_out),
        .interp_pc_load  (interp_pc_load),
        .interp_pc_target(interp_pc_target),
        .pc              (pc),
        .busy            (busy),
        .halted          (halted),
        .fault           (fault),
        .inst_count      (inst_count)
    );

    always #5 clk = ~clk;

    // Synchronous-read program memory.
    always @(posedge clk) mem_data_in <= prog[mem_addr];

    always @(posedge clk) begin
        if (rst) starts <= 0;
        else if (interp_start) starts <= starts + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Advance one clock; interpreter bus signals get fresh noise every cycle.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        interp_addr     = 8'($urandom);
        interp_rw       = 1'($urandom);
        interp_data_out = 16'($urandom);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; halt_req = 1'b0; interp_done = 1'b0;
        interp_pc_load = 1'b0; interp_pc_target = 8'h00;
        step();
        step();
        rst = 1'b0;
        pc_m = 8'h00;
        count_m = 16'h0000;
    endtask

    task automatic start_run();
        run = 1'b1;
        step();
        run = 1'b0;
    endtask

    // Runs one issued instruction from its FETCH cycle. lat = WAIT cycle that sees done.
    task automatic exec_one(input int lat, input bit load, input logic [7:0] tgt, input bit hreq);
        logic [15:0] inst_e;
        inst_e = prog[pc_m];
        n_cmp++; if (mem_addr !== pc_m || mem_rw !== 1'b0 || mem_data_out !== 16'h0) begin
            n_bad++; $display("FAIL fetch_bus: addr=%h rw=%b dout=%h required addr=%h rw=0 dout=0",
                              mem_addr, mem_rw, mem_data_out, pc_m); end
        n_cmp++; if (busy !== 1'b1 || interp_start !== 1'b0) begin
            n_bad++; $display("FAIL fetch_status: busy=%b start=%b required 1/0", busy, interp_start); end
        step(); // LATCH
        n_cmp++; if (interp_start !== 1'b0 || mem_rw !== 1'b0) begin
            n_bad++; $display("FAIL latch: start=%b rw=%b required 0/0", interp_start, mem_rw); end
        step(); // ISSUE
        n_cmp++; if (interp_start !== 1'b1 || interp_inst !== inst_e) begin
            n_bad++; $display("FAIL issue: start=%b inst=%h required 1/%h", interp_start, interp_inst,
                              inst_e); end
        interp_done = 1'($urandom); // must be ignored in ISSUE
        for (int k = 1; k <= lat; k++) begin
            step(); // WAIT
            if (hreq) halt_req = 1'b1;
            interp_done = (k == lat);
            interp_pc_load = (k == lat) ? load : 1'($urandom);
            interp_pc_target = (k == lat) ? tgt : 8'($urandom);
            #1;
            n_cmp++; if (mem_addr !== interp_addr || mem_rw !== interp_rw ||
                         mem_data_out !== interp_data_out || interp_start !== 1'b0) begin
                n_bad++; $display("FAIL wait_mux: addr=%h rw=%b dout=%h start=%b required %h/%b/%h/0",
                                  mem_addr, mem_rw, mem_data_out, interp_start, interp_addr,
                                  interp_rw, interp_data_out); end
            n_cmp++; if (fault !== 1'b0 || busy !== 1'b1) begin
                n_bad++; $display("FAIL wait_status: fault=%b busy=%b required 0/1", fault, busy); end
        end
        step(); // UPDATE
        interp_done = 1'b0;
        interp_pc_load = 1'($urandom);
        interp_pc_target = 8'($urandom);
        n_cmp++; if (pc !== pc_m || interp_inst !== inst_e || mem_rw !== 1'b0) begin
            n_bad++; $display("FAIL update: pc=%h inst=%h rw=%b required %h/%h/0", pc, interp_inst,
                              mem_rw, pc_m, inst_e); end
        step(); // next FETCH or IDLE
        halt_req = 1'b0;
        pc_m = load ? tgt : 8'((int'(pc_m) + 1) % 256);
        if (count_m != 16'hFFFF) count_m = count_m + 16'd1;
        n_cmp++; if (pc !== pc_m || inst_count !== count_m) begin
            n_bad++; $display("FAIL retire: pc=%h count=%0d required %h/%0d", pc, inst_count, pc_m,
                              count_m); end
        n_cmp++; if (busy !== !hreq) begin
            n_bad++; $display("FAIL after_update_busy: busy=%b required %b", busy, !hreq); end
    endtask

    // From FETCH of a HALT word: never issued, ends sticky in HALTED.
    task automatic exec_halt();
        n_cmp++; if (mem_addr !== pc_m) begin
            n_bad++; $display("FAIL halt_fetch: addr=%h required %h", mem_addr, pc_m); end
        step();
        step();
        for (int k = 0; k < 4; k++) begin
            run = 1'b1;
            n_cmp++; if (halted !== 1'b1 || busy !== 1'b0 || interp_start !== 1'b0 ||
                         pc !== pc_m || inst_count !== count_m) begin
                n_bad++; $display("FAIL halted: halted=%b busy=%b start=%b pc=%h count=%0d required 1/0/0/%h/%0d",
                                  halted, busy, interp_start, pc, inst_count, pc_m, count_m); end
            step();
        end
        run = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (pc !== 8'h00 || interp_inst !== 16'h0 || interp_start !== 1'b0 ||
                         mem_addr !== 8'h00 || mem_rw !== 1'b0 || mem_data_out !== 16'h0) begin
                n_bad++; $display("FAIL reset_outputs: pc=%h inst=%h start=%b addr=%h rw=%b dout=%h required all 0",
                                  pc, interp_inst, interp_start, mem_addr, mem_rw, mem_data_out); end
            n_cmp++; if (busy !== 1'b0 || halted !== 1'b0 || fault !== 1'b0 || inst_count !== 16'h0) begin
                n_bad++; $display("FAIL reset_status: busy=%b halted=%b fault=%b count=%0d required 0",
                                  busy, halted, fault, inst_count); end
            step();
        end
    endtask

    task automatic test_first_inst();
        do_reset();
        prog[0] = 16'h0401;
        start_run();
        exec_one(1, 1'b0, 8'h00, 1'b1);
        n_cmp++; if (starts !== 1) begin
            n_bad++; $display("FAIL first_starts: starts=%0d required 1", starts); end
    endtask

    task automatic test_opcode_program();
        logic [15:0] ops [8];
        ops = '{16'h0401, 16'h0C01, 16'h4000, 16'h5000, 16'h2801, 16'h6000, 16'h7000, 16'hF000};
        do_reset();
        for (int i = 0; i < 8; i++) prog[i] = ops[i];
        start_run();
        for (int i = 0; i < 7; i++) exec_one($urandom_range(1, 3), 1'b0, 8'h00, 1'b0);
        exec_halt();
        n_cmp++; if (starts !== 7 || pc !== 8'h07 || inst_count !== 16'd7) begin
            n_bad++; $display("FAIL program_totals: starts=%0d pc=%h count=%0d required 7/07/7",
                              starts, pc, inst_count); end
    endtask

    task automatic test_pc_load_wrap();
        do_reset();
        prog[8'h00] = 16'h1234;
        prog[8'h40] = 16'h2222;
        prog[8'hFF] = 16'h3333;
        prog[8'h00] = 16'h1234;
        start_run();
        exec_one(2, 1'b1, 8'h40, 1'b0); // next FETCH presents 8'h40
        exec_one(1, 1'b1, 8'hFF, 1'b0);
        exec_one(3, 1'b0, 8'h00, 1'b1); // 8'hFF + 1 wraps to 8'h00
        n_cmp++; if (pc !== 8'h00 || inst_count !== 16'd3) begin
            n_bad++; $display("FAIL wrap: pc=%h count=%0d required 00/3", pc, inst_count); end
    endtask

    task automatic test_timeout();
        do_reset();
        prog[8'h00] = 16'h1000;
        prog[8'h25] = 16'h1111;
        start_run();
        exec_one(1, 1'b1, 8'h25, 1'b0);
        step();
        step(); // ISSUE
        interp_done = 1'b0;
        for (int k = 1; k <= int'(TIMEOUT); k++) begin
            step();
            n_cmp++; if (fault !== 1'b0 || busy !== 1'b1) begin
                n_bad++; $display("FAIL timeout_early: cycle=%0d fault=%b busy=%b required 0/1",
                                  k, fault, busy); end
        end
        step();
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (fault !== 1'b1 || busy !== 1'b0 || halted !== 1'b0 || pc !== 8'h25 ||
                         mem_rw !== 1'b0) begin
                n_bad++; $display("FAIL timeout_fault: fault=%b busy=%b halted=%b pc=%h rw=%b required 1/0/0/25/0",
                                  fault, busy, halted, pc, mem_rw); end
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (fault !== 1'b0 || pc !== 8'h00 || inst_count !== 16'h0) begin
            n_bad++; $display("FAIL timeout_clear: fault=%b pc=%h count=%0d required 0/00/0",
                              fault, pc, inst_count); end
    endtask

    task automatic test_halt_resume();
        do_reset();
        for (int i = 0; i < 4; i++) prog[i] = 16'h0100 + 16'(i);
        start_run();
        exec_one(4, 1'b0, 8'h00, 1'b1); // halt_req raised in WAIT
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++; if (busy !== 1'b0 || interp_start !== 1'b0 || pc !== 8'h01) begin
                n_bad++; $display("FAIL idle_hold: busy=%b start=%b pc=%h required 0/0/01",
                                  busy, interp_start, pc); end
        end
        start_run(); // resumes at held pc
        exec_one(1, 1'b0, 8'h00, 1'b0);
        exec_one(2, 1'b0, 8'h00, 1'b1);
        n_cmp++; if (pc !== 8'h03 || inst_count !== 16'd3) begin
            n_bad++; $display("FAIL resume: pc=%h count=%0d required 03/3", pc, inst_count); end
    endtask

    task automatic test_rst_mid_wait();
        do_reset();
        prog[0] = 16'h3000;
        start_run();
        step();
        step(); // ISSUE
        interp_done = 1'b0;
        step(); // WAIT
        interp_rw = 1'b1;
        #1;
        n_cmp++; if (mem_rw !== 1'b1) begin
            n_bad++; $display("FAIL wait_write: rw=%b required 1", mem_rw); end
        rst = 1'b1;
        step();
        interp_rw = 1'b1;
        #1;
        rst = 1'b0;
        n_cmp++; if (mem_rw !== 1'b0 || busy !== 1'b0 || pc !== 8'h00 || interp_start !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid_wait: rw=%b busy=%b pc=%h start=%b required 0/0/00/0",
                              mem_rw, busy, pc, interp_start); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 256; i++) prog[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
        start_run();
        for (int i = 0; i < 40; i++) begin
            exec_one((i == 20) ? int'(TIMEOUT) : $urandom_range(1, 5),
                     ($urandom_range(0, 3) == 0), 8'($urandom), (i == 39));
        end
        prog[pc_m] = {4'hF, 12'($urandom)};
        start_run();
        exec_halt();
        n_cmp++; if (starts !== 40) begin
            n_bad++; $display("FAIL random_starts: starts=%0d required 40", starts); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
        interp_addr = 8'h00; interp_rw = 1'b0; interp_data_out = 16'h0;
        test_reset();
        test_first_inst();
        test_opcode_program();
        test_pc_load_wrap();
        test_timeout();
        test_halt_resume();
        test_rst_mid_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
